// File: rtl/xor32_rand_scheduler.sv
// One xorshift128 generator shared by NREQ requesters through a registered round-robin arbiter,
// with seed load / warm-up / run sequencing. Define XOR32_SCHED_COUNT_EN to build the oCount counter.
module xor32_rand_scheduler #(
  parameter int NREQ   = 4,
  parameter int WARMUP = 0
) (
  input  logic            iClk,
  input  logic            iRst,
  input  logic            iReseed,
  input  logic [127:0]    iSeed,
  input  logic [NREQ-1:0] iReq,
  output logic [NREQ-1:0] oGnt,
  output logic [31:0]     oRand,
  output logic            oReady,
  output logic [31:0]     oCount
);

  localparam int           PW        = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [127:0] SEED_RST  = {32'd88675123, 32'd521288629, 32'd362436069, 32'd123456789};
  localparam logic [7:0]   WARM_LAST = 8'(WARMUP - 1);

  typedef enum logic [1:0] {ST_LOAD, ST_WARM, ST_RUN} state_t;

  state_t          state_q;
  logic [31:0]     x_q, y_q, z_q, w_q;
  logic [31:0]     t_d, w_d;
  logic [7:0]      warm_q;
  logic [PW-1:0]   ptr_q;
  logic [PW-1:0]   pick_hi, pick_lo, pick_d;
  logic            found_hi, found_lo, found_d;
  logic [NREQ-1:0] onehot_d;
  logic [NREQ-1:0] gnt_q;
  logic [31:0]     rand_q;
  logic            ready_q;

  always_comb begin
    t_d = x_q ^ (x_q << 11);
    w_d = w_q ^ (w_q >> 19) ^ t_d ^ (t_d >> 8);
  end

  // Round-robin: the first request above the pointer wins, otherwise the first at or below it.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    pick_hi  = '0;
    pick_lo  = '0;
    found_hi = 1'b0;
    found_lo = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (iReq[k]) begin
        if (PW'(k) > ptr_q) begin
          if (!found_hi) begin
            found_hi = 1'b1;
            pick_hi  = PW'(k);
          end
        end else if (!found_lo) begin
          found_lo = 1'b1;
          pick_lo  = PW'(k);
        end
      end
    end
    found_d          = found_hi | found_lo;
    pick_d           = found_hi ? pick_hi : pick_lo;
    onehot_d         = '0;
    onehot_d[pick_d] = 1'b1;
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      {w_q, z_q, y_q, x_q} <= SEED_RST;
      warm_q  <= '0;
      ptr_q   <= PW'(NREQ - 1);
      gnt_q   <= '0;
      rand_q  <= '0;
      ready_q <= 1'b0;
      if (WARMUP > 0) state_q <= ST_WARM;
      else            state_q <= ST_RUN;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      gnt_q   <= '0;
      ready_q <= 1'b0;
      case (state_q)
        ST_LOAD: begin
          if (iSeed == '0) {w_q, z_q, y_q, x_q} <= SEED_RST;
          else             {w_q, z_q, y_q, x_q} <= iSeed;
          warm_q <= '0;
          if (!iReseed) begin
            if (WARMUP > 0) begin
              state_q <= ST_WARM;
            end else begin
              state_q <= ST_RUN;
              ready_q <= 1'b1;
            end
          end
        end
        ST_WARM: begin
          if (!iReseed) begin
            {w_q, z_q, y_q, x_q} <= {w_d, w_q, z_q, y_q};
            if (warm_q == WARM_LAST) begin
              state_q <= ST_RUN;
              ready_q <= 1'b1;
            end else begin
              warm_q <= warm_q + 8'd1;
            end
          end
        end
        default: begin
          if (!iReseed) begin
            ready_q <= 1'b1;
            if (found_d) begin
              gnt_q                <= onehot_d;
              rand_q               <= w_d;
              {w_q, z_q, y_q, x_q} <= {w_d, w_q, z_q, y_q};
              ptr_q                <= pick_d;
            end
          end
        end
      endcase
      // Reseed beats any grant decision and restarts LOAD from every state.
      if (iReseed) state_q <= ST_LOAD;
    end
  end

`ifdef XOR32_SCHED_COUNT_EN
  logic [31:0] count_q;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst)                                      count_q <= '0;
    else if (state_q == ST_LOAD)                   count_q <= '0;
    else if (state_q == ST_RUN && !iReseed && found_d) count_q <= count_q + 32'd1;
  end

  assign oCount = count_q;
`else
  assign oCount = '0;
`endif

  assign oGnt   = gnt_q;
  assign oRand  = rand_q;
  assign oReady = ready_q;

endmodule

// File: tb/tb_xor32_rand_scheduler.sv
// Self-checking bench: two schedulers (WARMUP 0 and 4) on shared stimulus, checked each cycle
// against a behavioural xorshift128/round-robin model, plus literal golden values.
module tb_xor32_rand_scheduler;

  localparam int           N        = 4;
  localparam logic [127:0] RST_SEED = {32'd88675123, 32'd521288629, 32'd362436069, 32'd123456789};
  localparam int           WU [2]   = '{0, 4};

  logic           clk    = 1'b0;
  logic           rst    = 1'b1;
  logic           reseed = 1'b0;
  logic [127:0]   seed   = '0;
  logic [N-1:0]   req    = '0;
  logic [N-1:0]   gnt0, gnt4;
  logic [31:0]    rand0, rand4, cnt0, cnt4;
  logic           rdy0, rdy4;
  logic [127:0]   tseed;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  xor32_rand_scheduler #(.NREQ(N), .WARMUP(0)) dut0 (
    .iClk(clk), .iRst(rst), .iReseed(reseed), .iSeed(seed), .iReq(req),
    .oGnt(gnt0), .oRand(rand0), .oReady(rdy0), .oCount(cnt0)
  );

  xor32_rand_scheduler #(.NREQ(N), .WARMUP(4)) dut4 (
    .iClk(clk), .iRst(rst), .iReseed(reseed), .iSeed(seed), .iReq(req),
    .oGnt(gnt4), .oRand(rand4), .oReady(rdy4), .oCount(cnt4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Whole-state xorshift128 step: {w,z,y,x} -> {w',w,z,y}.
  function automatic logic [127:0] xs_step(input logic [127:0] s);
    logic [31:0] x, w, t, nw;
    x  = s[31:0];
    w  = s[127:96];
    t  = x ^ (x << 11);
    nw = w ^ (w >> 19) ^ t ^ (t >> 8);
    return {nw, s[127:96], s[95:64], s[63:32]};
  endfunction

  function automatic logic [31:0] xs_nth(input logic [127:0] s, input int n);
    logic [127:0] v;
    v = s;
    for (int i = 0; i < n; i++) v = xs_step(v);
    return v[127:96];
  endfunction

  typedef enum {P_LOAD, P_WARM, P_RUN} phase_t;

  phase_t       ph    [2];
  logic [127:0] gs    [2];
  int           wdone [2];
  int           ptr   [2];
  logic [31:0]  ecnt  [2];
  logic [31:0]  erand [2];
  logic [N-1:0] egnt  [2];
  logic         erdy  [2];

  task automatic model_reset(input int d);
    if (WU[d] > 0) ph[d] = P_WARM;
    else           ph[d] = P_RUN;
    gs[d]    = RST_SEED;
    wdone[d] = 0;
    ptr[d]   = N - 1;
    ecnt[d]  = '0;
    erand[d] = '0;
    egnt[d]  = '0;
    erdy[d]  = 1'b0;
  endtask

  task automatic model_edge(input int d);
    int k;
    egnt[d] = '0;
    erdy[d] = 1'b0;
    case (ph[d])
      P_LOAD: begin
        gs[d]    = (seed == '0) ? RST_SEED : seed;
        ecnt[d]  = '0;
        wdone[d] = 0;
        if (WU[d] > 0) ph[d] = P_WARM;
        else begin
          ph[d]   = P_RUN;
          erdy[d] = 1'b1;
        end
      end
      P_WARM: if (!reseed) begin
        gs[d] = xs_step(gs[d]);
        wdone[d]++;
        if (wdone[d] == WU[d]) begin
          ph[d]   = P_RUN;
          erdy[d] = 1'b1;
        end
      end
      default: if (!reseed) begin
        erdy[d] = 1'b1;
        k = -1;
        for (int i = 1; i <= N; i++) begin
          int j;
          j = (ptr[d] + i) % N;
          if (k < 0 && ((32'(req) >> j) & 32'd1) != 0) k = j;
        end
        if (k >= 0) begin
          gs[d]    = xs_step(gs[d]);
          erand[d] = gs[d][127:96];
          egnt[d]  = N'(32'd1 << k);
          ptr[d]   = k;
          ecnt[d]  = ecnt[d] + 32'd1;
        end
      end
    endcase
    if (reseed) begin
      ph[d]   = P_LOAD;
      erdy[d] = 1'b0;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) model_reset(d);
      else     model_edge(d);
    end
  end

  task automatic cmp(input int d, input logic [N-1:0] g, input logic [31:0] r,
                     input logic y, input logic [31:0] c);
    check($sformatf("d%0d_gnt", d), 32'(g), 32'(egnt[d]));
    check($sformatf("d%0d_rand", d), r, erand[d]);
    check($sformatf("d%0d_ready", d), 32'(y), 32'(erdy[d]));
`ifdef XOR32_SCHED_COUNT_EN
    check($sformatf("d%0d_count", d), c, ecnt[d]);
`else
    check($sformatf("d%0d_count", d), c, 32'd0);
`endif
  endtask

  always @(negedge clk) begin
    cmp(0, gnt0, rand0, rdy0, cnt0);
    cmp(1, gnt4, rand4, rdy4, cnt4);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // Single requester after reset: three back-to-back golden words; WARMUP=4 copy waits 4 steps.
    req = 4'b0001;
    tick();
    check("first_gnt", 32'(gnt0), 32'd1);
    check("first_rand", rand0, 32'd3701687786);
    check("first_ready", 32'(rdy0), 32'd1);
    check("warm_gnt1", 32'(gnt4), 32'd0);
    check("warm_ready1", 32'(rdy4), 32'd0);
    tick();
    check("second_rand", rand0, 32'd458299110);
    check("warm_gnt2", 32'(gnt4), 32'd0);
    tick();
    check("third_rand", rand0, 32'd2500872618);
    check("warm_gnt3", 32'(gnt4), 32'd0);
    tick();
    check("warm_gnt4", 32'(gnt4), 32'd0);
    tick();
    check("warm_first_gnt", 32'(gnt4), 32'd1);
    check("warm_first_rand", rand4, xs_nth(RST_SEED, 5));

    // Asynchronous reset between edges clears outputs at once.
    #1 rst = 1'b1;
    #1;
    check("arst_gnt", 32'(gnt0), 32'd0);
    check("arst_rand", rand0, 32'd0);
    check("arst_ready", 32'(rdy0), 32'd0);
    check("arst_count", cnt0, 32'd0);
    check("arst_rand4", rand4, 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;

    // All four requesting: strict rotation from requester 0, sequence restarts.
    req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("rr_gnt%0d", i), 32'(gnt0), 32'd1 << (i % N));
      if (i == 0) check("rr_restart_rand", rand0, 32'd3701687786);
    end

    // Zero seed falls back to the reset constants.
    req = 4'b0010; seed = '0; reseed = 1'b1;
    tick();
    check("zseed_nogrant", 32'(gnt0), 32'd0);
    check("zseed_load_ready", 32'(rdy0), 32'd0);
    reseed = 1'b0;
    tick();
    check("zseed_load_gnt", 32'(gnt0), 32'd0);
    tick();
    check("zseed_gnt", 32'(gnt0), 32'd2);
    check("zseed_rand", rand0, 32'd3701687786);
`ifdef XOR32_SCHED_COUNT_EN
    check("zseed_count", cnt0, 32'd1);
`endif

    // Reseed coinciding with a grant decision.
    tseed = {$urandom(), $urandom(), $urandom(), $urandom()} | 128'd1;
    seed = tseed; req = 4'b0100; reseed = 1'b1;
    tick();
    check("rs_nogrant", 32'(gnt0), 32'd0);
    reseed = 1'b0;
    tick();
    tick();
    check("rs_gnt", 32'(gnt0), 32'd4);
    check("rs_rand", rand0, xs_nth(tseed, 1));

    // Pointer survives reseed: from pointer 2, requests {3,1} must pick 3.
    req = 4'b1010; reseed = 1'b1;
    tick();
    reseed = 1'b0;
    tick();
    tick();
    check("ptr_keep_gnt", 32'(gnt0), 32'd8);
    check("ptr_keep_rand", rand0, xs_nth(tseed, 1));

    // Randomized traffic with occasional reseeds and resets.
    for (int i = 0; i < 600; i++) begin
      req = N'($urandom());
      if ($urandom_range(0, 29) == 0) begin
        reseed = 1'b1;
        if ($urandom_range(0, 3) == 0) seed = '0;
        else seed = {$urandom(), $urandom(), $urandom(), $urandom()};
      end else begin
        reseed = 1'b0;
      end
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
      tick();
    end

    reseed = 1'b0;
    req    = '0;
    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
